// File: rtl/connect4_turn_controller.sv
// rtl/connect4_turn_controller.sv - turn sequencing, gravity placement and turn timeout for a 4x4 Connect-4 board
module connect4_turn_controller #(
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        drop,
  input  logic [1:0]  col_sel,
  input  logic [1:0]  game_status,
  output logic [15:0] game_board,
  output logic [15:0] player_cells,
  output logic        current_player,
  output logic [1:0]  ctrl_state,
  output logic        move_error,
  output logic        turn_timeout,
  output logic        game_over,
  output logic [1:0]  result,
  output logic [4:0]  move_count
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'b00,
    S_PLACE = 2'b01,
    S_CHECK = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // With the timeout disabled this wraps to all ones, but it is never consulted
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic                 drop_q;
  logic [TIMEOUT_W-1:0] timer;
  logic [1:0]           col_q;
  logic                 drop_rise;
  logic                 col_full;
  logic                 timer_expired;
  logic [15:0]          place_mask;

  assign drop_rise     = drop & ~drop_q;
  assign col_full      = game_board[{2'b11, col_sel}];
  assign timer_expired = TIMEOUT_EN && (timer == TIMER_LAST);
  assign ctrl_state    = state;

  // Gravity: scan top to bottom so the lowest empty cell of the latched column wins
  always_comb begin
    place_mask = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!game_board[{r[1:0], col_q}]) begin
        place_mask = 16'h0001 << {r[1:0], col_q};
      end
    end
  end

  // Next-state selection; new_game returns to S_WAIT from anywhere
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:  if (drop_rise && !col_full) state_next = S_PLACE;
      S_PLACE: state_next = S_CHECK;
      S_CHECK: state_next = (game_status != 2'b00) ? S_OVER : S_WAIT;
      default: state_next = S_OVER;
    endcase
    if (new_game) state_next = S_WAIT;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_WAIT;
    else        state <= state_next;
  end

  // Drop edge detector keeps sampling through new_game so a held level never retriggers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= 1'b0;
    else        drop_q <= drop;
  end

  // Board, turn, timer and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_board     <= '0;
      player_cells   <= '0;
      current_player <= 1'b0;
      move_error     <= 1'b0;
      turn_timeout   <= 1'b0;
      game_over      <= 1'b0;
      result         <= 2'b00;
      move_count     <= '0;
      timer          <= '0;
      col_q          <= 2'b00;
    end else if (new_game) begin
      game_board     <= '0;
      player_cells   <= '0;
      current_player <= 1'b0;
      move_error     <= 1'b0;
      turn_timeout   <= 1'b0;
      game_over      <= 1'b0;
      result         <= 2'b00;
      move_count     <= '0;
      timer          <= '0;
      col_q          <= 2'b00;
    end else begin
      move_error   <= 1'b0;
      turn_timeout <= 1'b0;
      case (state)
        S_WAIT: begin
          if (drop_rise && !col_full) begin
            col_q <= col_sel;
            timer <= '0;
          end else begin
            if (drop_rise) move_error <= 1'b1;
            if (timer_expired) begin
              turn_timeout   <= 1'b1;
              current_player <= ~current_player;
              timer          <= '0;
            end else begin
              timer <= timer + TIMEOUT_W'(1);
            end
          end
        end
        S_PLACE: begin
          if (place_mask != 16'h0000) begin
            game_board   <= game_board | place_mask;
            player_cells <= current_player ? (player_cells | place_mask)
                                           : (player_cells & ~place_mask);
            move_count   <= move_count + 5'd1;
          end
        end
        S_CHECK: begin
          if (game_status != 2'b00) begin
            result    <= game_status;
            game_over <= 1'b1;
          end else begin
            current_player <= ~current_player;
            timer          <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_turn_controller.sv
// tb/tb_connect4_turn_controller.sv - self-checking bench for connect4_turn_controller
module tb_connect4_turn_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        drop;
  logic [1:0]  col_sel;

  logic [15:0] board_a, cells_a, board_t, cells_t;
  logic [1:0]  status_a, status_t, state_a, state_tt, result_a, result_t;
  logic        cp_a, cp_t, err_a, err_t, to_a, to_t, over_a, over_t;
  logic [4:0]  count_a, count_t;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] col;
    logic       exp_over;
  } move_t;

  typedef struct {
    logic [15:0] board;
    logic [15:0] cells;
    logic [4:0]  count;
  } exp_t;

  exp_t        sb[$];
  int          height[4];
  logic [15:0] m_board, m_cells;
  logic        m_player;
  int          m_count;

  always #5 clk = ~clk;

  // Reference win detector: rows, columns and both diagonals
  function automatic logic [1:0] detect(input logic [15:0] b, input logic [15:0] p);
    logic [15:0] m;
    logic p1, p2;
    p1 = 1'b0;
    p2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 4)       m = 16'h000F << (4 * i);
      else if (i < 8)  m = 16'h1111 << (i - 4);
      else if (i == 8) m = 16'h8421;
      else             m = 16'h1248;
      if ((b & m) == m) begin
        if ((p & m) == 16'h0000) p1 = 1'b1;
        else if ((p & m) == m)   p2 = 1'b1;
      end
    end
    if (p1) return 2'b01;
    if (p2) return 2'b10;
    if (b == 16'hFFFF) return 2'b11;
    return 2'b00;
  endfunction

  assign status_a = detect(board_a, cells_a);
  assign status_t = detect(board_t, cells_t);

  connect4_turn_controller #(.TIMEOUT_W(20), .TIMEOUT_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .drop(drop), .col_sel(col_sel),
    .game_status(status_a), .game_board(board_a), .player_cells(cells_a),
    .current_player(cp_a), .ctrl_state(state_a), .move_error(err_a),
    .turn_timeout(to_a), .game_over(over_a), .result(result_a), .move_count(count_a)
  );

  connect4_turn_controller #(.TIMEOUT_W(20), .TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .reset(reset), .new_game(new_game), .drop(drop), .col_sel(col_sel),
    .game_status(status_t), .game_board(board_t), .player_cells(cells_t),
    .current_player(cp_t), .ctrl_state(state_tt), .move_error(err_t),
    .turn_timeout(to_t), .game_over(over_t), .result(result_t), .move_count(count_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) height[c] = 0;
    m_board  = '0;
    m_cells  = '0;
    m_player = 1'b0;
    m_count  = 0;
    sb.delete();
  endtask

  task automatic new_game_pulse();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
  endtask

  task automatic do_move(input logic [1:0] col, input logic exp_over);
    exp_t e;
    int   idx;
    int   waited;
    @(negedge clk);
    col_sel = col;
    drop    = 1'b1;
    idx = 4 * height[col] + int'(col);
    m_board[idx] = 1'b1;
    m_cells[idx] = m_player;
    height[col]++;
    m_count++;
    e.board = m_board;
    e.cells = m_cells;
    e.count = 5'(m_count);
    sb.push_back(e);
    @(negedge clk);
    drop   = 1'b0;
    waited = 0;
    while (state_a != 2'b10 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("place_latency", waited, 1);
    e = sb.pop_front();
    check("board", board_a, e.board);
    check("cells", cells_a, e.cells);
    check("count", count_a, e.count);
    @(negedge clk);
    check("state_after_move", state_a, exp_over ? 2'b11 : 2'b00);
    if (!exp_over) m_player = ~m_player;
    check("player_after_move", cp_a, m_player);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_board"}, board_a, 0);
    check({tag, "_cells"}, cells_a, 0);
    check({tag, "_player"}, cp_a, 0);
    check({tag, "_state"}, state_a, 0);
    check({tag, "_error"}, err_a, 0);
    check({tag, "_timeout"}, to_a, 0);
    check({tag, "_over"}, over_a, 0);
    check({tag, "_result"}, result_a, 0);
    check({tag, "_count"}, count_a, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    vert_cols[7] = '{0, 1, 0, 1, 0, 1, 0};
    int    tie_cols[16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};
    move_t vert[7];
    move_t tie[16];
    int    err_cnt;
    int    err_seen;

    for (int i = 0; i < 7; i++) begin
      vert[i].col      = 2'(vert_cols[i]);
      vert[i].exp_over = (i == 6);
    end
    for (int i = 0; i < 16; i++) begin
      tie[i].col      = 2'(tie_cols[i]);
      tie[i].exp_over = (i == 15);
    end

    reset    = 1'b0;
    new_game = 1'b0;
    drop     = 1'b0;
    col_sel  = 2'b00;
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Vertical win for P1 in column 0
    for (int i = 0; i < 7; i++) do_move(vert[i].col, vert[i].exp_over);
    check("vert_board", board_a, 16'h1333);
    check("vert_cells", cells_a, 16'h0222);
    check("vert_result", result_a, 2'b01);
    check("vert_over", over_a, 1);
    check("vert_state", state_a, 2'b11);
    check("vert_count", count_a, 7);

    // Drops after the game ends are ignored
    @(negedge clk);
    col_sel  = 2'd3;
    drop     = 1'b1;
    err_seen = 0;
    repeat (4) begin
      @(negedge clk);
      drop = 1'b0;
      if (err_a) err_seen = 1;
    end
    check("over_board_frozen", board_a, 16'h1333);
    check("over_count_frozen", count_a, 7);
    check("over_state_frozen", state_a, 2'b11);
    check("over_no_error", err_seen, 0);

    // new_game from S_OVER clears on the next edge
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    check_all_zero("new_game");
    new_game = 1'b0;
    model_clear();

    // Full column rejects the fifth drop
    for (int i = 0; i < 4; i++) do_move(2'd2, 1'b0);
    @(negedge clk);
    col_sel = 2'd2;
    drop    = 1'b1;
    err_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drop = 1'b0;
      if (err_a) err_cnt++;
    end
    check("full_error_pulses", err_cnt, 1);
    check("full_board", board_a, 16'h4444);
    check("full_player", cp_a, 0);
    check("full_count", count_a, 4);
    check("full_state", state_a, 2'b00);

    // Tie game filling the whole board
    new_game_pulse();
    for (int i = 0; i < 16; i++) do_move(tie[i].col, tie[i].exp_over);
    check("tie_board", board_a, 16'hFFFF);
    check("tie_cells", cells_a, 16'h3C3C);
    check("tie_result", result_a, 2'b11);
    check("tie_count", count_a, 16);
    check("tie_over", over_a, 1);

    // A held drop places exactly one piece
    new_game_pulse();
    @(negedge clk);
    col_sel = 2'd0;
    drop    = 1'b1;
    repeat (20) @(negedge clk);
    drop = 1'b0;
    repeat (3) @(negedge clk);
    check("held_count", count_a, 1);
    check("held_board", board_a, 16'h0001);
    check("held_state", state_a, 2'b00);
    check("held_player", cp_a, 1);

    // Asynchronous reset in the middle of a placement
    new_game_pulse();
    do_move(2'd0, 1'b0);
    do_move(2'd1, 1'b0);
    @(negedge clk);
    col_sel = 2'd2;
    drop    = 1'b1;
    @(posedge clk);
    #2;
    check("abort_in_place", state_a, 2'b01);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    drop = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_board_after", board_a, 0);
    check("abort_count_after", count_a, 0);
    check("abort_state_after", state_a, 2'b00);
    model_clear();

    // Turn timeout after eight idle cycles
    new_game_pulse();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("timeout_pulse", to_t, (k == 8));
    end
    check("timeout_player", cp_t, 1);
    @(negedge clk);
    check("timeout_one_cycle", to_t, 0);
    check("timeout_no_error", err_t, 0);
    check("timeout_not_over", over_t, 0);
    check("timeout_result", result_t, 0);

    // A drop in the expiry cycle wins over the timeout
    new_game_pulse();
    repeat (7) @(negedge clk);
    col_sel = 2'd0;
    drop    = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    check("expiry_drop_no_timeout", to_t, 0);
    check("expiry_drop_state", state_tt, 2'b01);
    check("expiry_drop_player", cp_t, 0);
    @(negedge clk);
    check("expiry_drop_board", board_t, 16'h0001);
    check("expiry_drop_cells", cells_t, 16'h0000);
    check("expiry_drop_count", count_t, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/connect4_turn_controller.md
Name: connect4_turn_controller

Overview:
Sequences a 4x4 Connect-4 game. It takes column-drop requests from the player interface and applies gravity to place each piece. It owns the game_board and player_cells registers that feed the win detector, alternates turns, and enforces a per-turn timeout. It samples the detector's game_status after every placement and freezes the board once a win or tie is reported.

Parameters:
TIMEOUT_W, 20, width of the turn timer.
TIMEOUT_CYCLES, 1000000, idle cycles in S_WAIT before the current turn is forfeited; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
new_game  input  1  synchronous clear of the whole game; highest priority after reset.
drop  input  1  level request from the player interface; only its rising edge acts.
col_sel  input  2  target column 0..3.
game_status  input  2  from the win detector: 00 playing, 01 P1 wins, 10 P2 wins, 11 tie.
game_board  output  16  occupancy, 1 = occupied.
player_cells  output  16  owner per cell, 1 = player 2, 0 = player 1.
current_player  output  1  0 = P1, 1 = P2.
ctrl_state  output  2  FSM state encoding.
move_error  output  1  one-cycle pulse on a drop into a full column.
turn_timeout  output  1  one-cycle pulse when a turn is forfeited.
game_over  output  1  high while in S_OVER.
result  output  2  game_status latched on entry to S_OVER; 00 otherwise.
move_count  output  5  pieces placed, 0..16.

Behaviour:
- Cell mapping: bit = 4*r + c, with r = 0 as the bottom row (bits 3:0) and r = 3 as the top row (bits 15:12). Column c uses bits c, 4+c, 8+c, 12+c.
- Reset (reset = 0, asynchronous): every output and internal register is cleared to 0, including drop_q, the timer, and the latched column. The FSM enters S_WAIT. Reset asserted in any state, including S_PLACE or S_CHECK, aborts the move with no partial update.
- drop_rise = drop & ~drop_q. drop_q is registered every cycle in all states.
- FSM states: S_WAIT = 00, S_PLACE = 01, S_CHECK = 10, S_OVER = 11.
- S_WAIT:
  - On drop_rise with bit 12+col_sel = 1 (column full): move_error = 1 for exactly one cycle. The FSM stays in S_WAIT, the board and current_player are unchanged, and the timer keeps running.
  - On drop_rise into a non-full column: latch col_sel into col_q, clear the timer, go to S_PLACE.
  - Otherwise: timer++. When the timer equals TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES != 0): turn_timeout pulses for one cycle, current_player toggles, the timer clears.
  - If drop_rise and timer expiry coincide, the drop wins and no timeout occurs.
- S_PLACE (one cycle):
  - Set the lowest clear bit among col_q, 4+col_q, 8+col_q, 12+col_q in game_board.
  - Write current_player into the same bit of player_cells.
  - move_count++. Go to S_CHECK.
- S_CHECK (one cycle): the detector is combinational on the registered board, so game_status is valid this cycle.
  - If game_status != 00: result <= game_status, game_over <= 1, go to S_OVER.
  - Otherwise: toggle current_player, clear the timer, go to S_WAIT.
  - Move latency is therefore drop_rise -> board updated after 1 clock -> turn handoff or game_over after 2 clocks.
- S_OVER: the board, result, and move_count are frozen. drop and the timer are ignored; move_error and turn_timeout stay 0.
- new_game = 1 in any state: same effect as reset on the next clock edge, except drop_q is still sampled. It overrides drop_rise in the same cycle.
- A piece is never written to an occupied cell. move_count never exceeds 16. col_sel is sampled only on drop_rise.

Test Plan:
The bench instantiates the win detector on game_board, player_cells, and game_status.
- Vertical win: columns 0,1,0,1,0,1,0 -> game_board = 0x1333, player_cells = 0x0222, result = 01, game_over = 1, ctrl_state = 11, move_count = 7. A further drop changes nothing.
- Column full: four drops into column 2, then a fifth into column 2 -> exactly one move_error pulse, game_board stays 0x4444, current_player stays 0, move_count = 4.
- Tie, TIMEOUT_CYCLES = 0: columns 0,2,1,3,2,0,3,1,0,2,1,3,2,0,3,1 -> game_board = 0xFFFF, player_cells = 0x3C3C, result = 11, move_count = 16. No win is reported at any intermediate step.
- Timeout, TIMEOUT_CYCLES = 8: idle in S_WAIT -> turn_timeout pulses on the 8th cycle and current_player goes 0->1. A drop in the expiry cycle places a P1 piece with no timeout pulse.
- drop held high for 20 cycles -> exactly one piece placed, move_count = 1.
- Reset and new_game:
  - reset low during S_PLACE -> all outputs 0 immediately, no piece placed.
  - new_game in S_OVER -> the board clears on the next edge, ctrl_state = 00, current_player = 0, result = 00.
